edt_tdr_sequencer: RTL and testbench

EDT_TDR_SEQUENCER -- requirements
Module: edt_tdr_sequencer

---
 rtl/edt_tdr_seq_pkg.sv | 16 +
 rtl/edt_tdr_sequencer.sv | 145 ++++++++++++++
 tb/tb_edt_tdr_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/edt_tdr_seq_pkg.sv
// rtl/edt_tdr_seq_pkg.sv - shared state type and constants for the EDT TDR sequencer
package edt_tdr_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_UPDATE  = 3'd3,
    ST_DONE    = 3'd4
  } seq_state_e;

  localparam int TDR_LEN_DEFAULT = 2;
  localparam int BYPASS_BIT      = 0;
  localparam int LPS_BIT         = 1;

endpackage

// File: rtl/edt_tdr_sequencer.sv
// rtl/edt_tdr_sequencer.sv - programs the EDT TDR over IJTAG, returning the prior value
module edt_tdr_sequencer
  import edt_tdr_seq_pkg::*;
#(
  parameter int TDR_LEN = TDR_LEN_DEFAULT
) (
  input  logic               ijtag_tck,
  input  logic               ijtag_reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [TDR_LEN-1:0] cfg_data,
  output logic [TDR_LEN-1:0] rd_data,
  output logic               done,
  input  logic               host_sel,
  input  logic               host_ce,
  input  logic               host_se,
  input  logic               host_ue,
  input  logic               host_si,
  output logic               host_so,
  output logic               host_blocked,
  output logic               tdr_sel,
  output logic               tdr_ce,
  output logic               tdr_se,
  output logic               tdr_ue,
  output logic               tdr_si,
  input  logic               tdr_so
);

  localparam int CNT_W = $clog2(TDR_LEN + 1);

  seq_state_e         state_q, state_d;
  logic [TDR_LEN-1:0] sr_q, sr_d;
  logic [TDR_LEN-1:0] rd_data_q, rd_data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               host_blocked_q, host_blocked_d;
  logic               sel_q, sel_d;
  logic               ce_q, ce_d;
  logic               se_q, se_d;
  logic               ue_q, ue_d;
  logic               si_q, si_d;
  logic               handshake;

  // The host keeps the TDR while it has it selected; requests wait behind it.
  assign cfg_ready = ~host_blocked_q & ~host_sel;
  assign handshake = cfg_valid & cfg_ready;

  always_comb begin
    state_d        = state_q;
    sr_d           = sr_q;
    rd_data_d      = rd_data_q;
    cnt_d          = cnt_q;
    done_d         = 1'b0;
    host_blocked_d = 1'b1;
    sel_d          = 1'b0;
    ce_d           = 1'b0;
    se_d           = 1'b0;
    ue_d           = 1'b0;
    si_d           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        host_blocked_d = 1'b0;
        if (handshake) begin
          sr_d           = cfg_data;
          state_d        = ST_CAPTURE;
          host_blocked_d = 1'b1;
          sel_d          = 1'b1;
          ce_d           = 1'b1;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_SHIFT;
        cnt_d   = '0;
        sel_d   = 1'b1;
        se_d    = 1'b1;
        si_d    = sr_q[0];
      end
      ST_SHIFT: begin
        // Same register shifts cfg bits out of the LSB and captured bits in at the MSB.
        sr_d  = TDR_LEN'({tdr_so, sr_q} >> 1);
        sel_d = 1'b1;
        if (cnt_q == CNT_W'(TDR_LEN - 1)) begin
          state_d = ST_UPDATE;
          ue_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          se_d  = 1'b1;
          si_d  = sr_d[0];
        end
      end
      ST_UPDATE: begin
        state_d   = ST_DONE;
        done_d    = 1'b1;
        rd_data_d = sr_q;
      end
      ST_DONE: begin
        state_d        = ST_IDLE;
        host_blocked_d = 1'b0;
      end
      default: begin
        state_d        = ST_IDLE;
        host_blocked_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state_q        <= ST_IDLE;
      sr_q           <= '0;
      rd_data_q      <= '0;
      cnt_q          <= '0;
      done_q         <= 1'b0;
      host_blocked_q <= 1'b0;
      sel_q          <= 1'b0;
      ce_q           <= 1'b0;
      se_q           <= 1'b0;
      ue_q           <= 1'b0;
      si_q           <= 1'b0;
    end else begin
      state_q        <= state_d;
      sr_q           <= sr_d;
      rd_data_q      <= rd_data_d;
      cnt_q          <= cnt_d;
      done_q         <= done_d;
      host_blocked_q <= host_blocked_d;
      sel_q          <= sel_d;
      ce_q           <= ce_d;
      se_q           <= se_d;
      ue_q           <= ue_d;
      si_q           <= si_d;
    end
  end

  assign tdr_sel      = host_blocked_q ? sel_q : host_sel;
  assign tdr_ce       = host_blocked_q ? ce_q  : host_ce;
  assign tdr_se       = host_blocked_q ? se_q  : host_se;
  assign tdr_ue       = host_blocked_q ? ue_q  : host_ue;
  assign tdr_si       = host_blocked_q ? si_q  : host_si;
  assign host_so      = tdr_so;
  assign host_blocked = host_blocked_q;
  assign done         = done_q;
  assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_edt_tdr_sequencer.sv
// tb/tb_edt_tdr_sequencer.sv - randomized self-checking bench for edt_tdr_sequencer
module tb_edt_tdr_sequencer;
  import edt_tdr_seq_pkg::*;

  localparam int L = TDR_LEN_DEFAULT;

  logic         clk = 1'b0;
  logic         rstn;
  logic         cfg_valid, cfg_ready, done;
  logic [L-1:0] cfg_data, rd_data;
  logic         host_sel, host_ce, host_se, host_ue, host_si, host_so, host_blocked;
  logic         tdr_sel, tdr_ce, tdr_se, tdr_ue, tdr_si, tdr_so;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  edt_tdr_sequencer #(.TDR_LEN(L)) dut (
    .ijtag_tck(clk), .ijtag_reset(rstn),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .rd_data(rd_data), .done(done),
    .host_sel(host_sel), .host_ce(host_ce), .host_se(host_se), .host_ue(host_ue),
    .host_si(host_si), .host_so(host_so), .host_blocked(host_blocked),
    .tdr_sel(tdr_sel), .tdr_ce(tdr_ce), .tdr_se(tdr_se), .tdr_ue(tdr_ue),
    .tdr_si(tdr_si), .tdr_so(tdr_so)
  );

  // Target EDT TDR: capture/shift/update on posedge, scan-out retimed on negedge.
  logic [L-1:0] t_sr, t_lat;
  logic         t_so;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      t_sr  <= '0;
      t_lat <= '0;
    end else if (tdr_sel) begin
      if (tdr_ce)      t_sr <= t_lat;
      else if (tdr_se) t_sr <= L'({tdr_si, t_sr} >> 1);
      if (tdr_ue)      t_lat <= t_sr;
    end
  end
  always @(negedge clk or negedge rstn) begin
    if (!rstn) t_so <= 1'b0;
    else       t_so <= t_sr[0];
  end
  assign tdr_so = t_so;

  // Reference: cycle k after an accepted request is capture (1), shift (2..L+1),
  // update (L+2), done (L+3); the old value is whatever the TDR held at acceptance.
  int           m_phase;
  logic [L-1:0] m_cfg, m_old, m_rd;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_phase <= 0;
      m_rd    <= '0;
    end else if (m_phase == 0) begin
      if (cfg_valid && !host_sel) begin
        m_phase <= 1;
        m_cfg   <= cfg_data;
        m_old   <= t_lat;
      end
    end else if (m_phase == L + 3) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
      if (m_phase == L + 2) m_rd <= m_old;
    end
  end

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, required %b at %0t", name, act, exp, $time);
  endtask

  task automatic checkv(input string name, input logic [L-1:0] act, input logic [L-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, required %b at %0t", name, act, exp, $time);
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    logic [L-1:0] sh;
    logic e_sel, e_ce, e_se, e_ue, e_si;
    if (m_phase == 0) begin
      check1("pass_sel", tdr_sel, host_sel);
      check1("pass_ce", tdr_ce, host_ce);
      check1("pass_se", tdr_se, host_se);
      check1("pass_ue", tdr_ue, host_ue);
      check1("pass_si", tdr_si, host_si);
      check1("cfg_ready_idle", cfg_ready, !host_sel);
    end else begin
      e_sel = (m_phase <= L + 2);
      e_ce  = (m_phase == 1);
      e_se  = (m_phase >= 2) && (m_phase <= L + 1);
      e_ue  = (m_phase == L + 2);
      sh    = m_cfg >> (e_se ? m_phase - 2 : 0);
      e_si  = e_se & sh[0];
      check1("seq_sel", tdr_sel, e_sel);
      check1("seq_ce", tdr_ce, e_ce);
      check1("seq_se", tdr_se, e_se);
      check1("seq_ue", tdr_ue, e_ue);
      check1("seq_si", tdr_si, e_si);
      check1("cfg_ready_busy", cfg_ready, 1'b0);
      if (m_phase == L + 3) checkv("tdr_value_at_done", t_lat, m_cfg);
    end
    check1("host_blocked", host_blocked, m_phase != 0);
    check1("done", done, m_phase == L + 3);
    checkv("rd_data", rd_data, m_rd);
    check1("host_so", host_so, tdr_so);
  end

  task automatic host_idle();
    host_sel = 1'b0; host_ce = 1'b0; host_se = 1'b0; host_ue = 1'b0; host_si = 1'b0;
  endtask

  task automatic run_req(input logic [L-1:0] data, input int exp_wait, input logic toggle,
                         output logic [L-1:0] rd);
    int waited = 0;
    int lat = 0;
    cfg_data  = data;
    cfg_valid = 1'b1;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (m_phase != 1 && waited < 20);
    cfg_valid = 1'b0;
    checki("handshake_wait", waited, exp_wait);
    do begin
      @(negedge clk);
      lat++;
      check1("blocked_while_busy", host_blocked, 1'b1);
      if (!done && toggle) begin
        #1;
        host_sel = 1'($urandom); host_ce = 1'($urandom); host_se = 1'($urandom);
        host_ue  = 1'($urandom); host_si = 1'($urandom);
      end
    end while (!done && lat < 20);
    host_idle();
    checki("done_latency", lat, 5);
    rd = rd_data;
  endtask

  initial begin
    logic [L-1:0] rd;
    rstn = 1'b1;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    host_idle();
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check1("reset_done", done, 1'b0);
    checkv("reset_rd_data", rd_data, 2'b00);
    check1("reset_blocked", host_blocked, 1'b0);
    check1("reset_cfg_ready", cfg_ready, 1'b1);

    run_req(2'b11, 1, 1'b0, rd);
    checkv("req1_rd_data", rd, 2'b00);
    check1("req1_bypass", t_lat[BYPASS_BIT], 1'b1);
    check1("req1_lps", t_lat[LPS_BIT], 1'b1);

    run_req(2'b01, 2, 1'b1, rd);
    checkv("req2_rd_data", rd, 2'b11);
    check1("req2_bypass", t_lat[BYPASS_BIT], 1'b1);
    check1("req2_lps", t_lat[LPS_BIT], 1'b0);

    @(negedge clk);
    cfg_data = 2'b10; cfg_valid = 1'b1;
    host_sel = 1'b1; host_ce = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check1("host_prio_ready", cfg_ready, 1'b0);
      check1("host_prio_blocked", host_blocked, 1'b0);
      host_ce = 1'b0; host_se = 1'b1; host_si = 1'($urandom);
      #1 check1("host_prio_pass_si", tdr_si, host_si);
    end
    host_idle();
    run_req(2'b10, 1, 1'b0, rd);
    checkv("req3_rd_data", rd, 2'b01);
    checkv("req3_tdr_value", t_lat, 2'b10);

    @(negedge clk);
    cfg_data = 2'b11; cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    check1("abort_done", done, 1'b0);
    check1("abort_blocked", host_blocked, 1'b0);
    checkv("abort_rd_data", rd_data, 2'b00);
    checkv("abort_tdr_value", t_lat, 2'b00);
    check1("abort_tdr_sel", tdr_sel, 1'b0);
    @(posedge clk); #3;
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check1("no_done_after_abort", done, 1'b0);
    end

    for (int cyc = 0; cyc < 2500; cyc++) begin
      @(posedge clk); #1;
      if (!rstn) rstn = 1'b1;
      if (cfg_valid && m_phase == 1) cfg_valid = 1'b0;
      host_sel = ($urandom_range(0, 2) == 0);
      host_ce  = 1'($urandom); host_se = 1'($urandom);
      host_ue  = 1'($urandom); host_si = 1'($urandom);
      if (!cfg_valid && $urandom_range(0, 3) == 0) begin
        cfg_data  = L'($urandom);
        cfg_valid = 1'b1;
      end
      if ($urandom_range(0, 199) == 0) begin
        rstn      = 1'b0;
        cfg_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    cfg_valid = 1'b0;
    host_idle();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
